// File: rtl/game_draw_ctrl_pkg.sv
// Shared constants, state type and LFSR step function for the game draw controller.
package game_draw_ctrl_pkg;

  localparam int unsigned NUM_GAMES = 128;
  localparam int unsigned IDX_W     = 7;

  // Feedback taps for x^7 + x^6 + 1 (bits 6 and 5 of the shift register).
  localparam logic [IDX_W-1:0] LFSR_TAPS = 7'h60;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StCommit,
    StExhausted
  } draw_state_e;

  function automatic logic [IDX_W-1:0] lfsr_step(input logic [IDX_W-1:0] v);
    return {v[IDX_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/game_draw_ctrl_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR; loads SEED on reset and steps every clock.
module game_draw_ctrl_lfsr7
  import game_draw_ctrl_pkg::*;
#(
  parameter logic [IDX_W-1:0] SEED = 7'h5A
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [IDX_W-1:0] value
);

  logic [IDX_W-1:0] value_q, value_d;

  always_comb begin
    value_d = lfsr_step(value_q);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/game_draw_ctrl.sv
// Random game draw controller driving an external free-slot selector.
// Define GAME_DRAW_AUTO_CLEAR_EN to auto-clear the played flags on exhaustion.
module game_draw_ctrl
  import game_draw_ctrl_pkg::*;
#(
  parameter logic [IDX_W-1:0] LFSR_SEED = 7'h5A
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req,
  input  logic                 clear_all,
  output logic [NUM_GAMES-1:0] used_mask,
  output logic [IDX_W-1:0]     rand_start,
  input  logic [IDX_W-1:0]     sel_index,
  input  logic                 sel_valid,
  output logic [IDX_W-1:0]     game_index,
  output logic                 done,
  output logic                 busy,
  output logic                 exhausted
);

  draw_state_e          state_q, state_d;
  logic [NUM_GAMES-1:0] used_mask_q, used_mask_d;
  logic [IDX_W-1:0]     rand_start_q, rand_start_d;
  logic [IDX_W-1:0]     game_index_q, game_index_d;
  logic [IDX_W-1:0]     lfsr_value;

  game_draw_ctrl_lfsr7 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .value   (lfsr_value)
  );

  always_comb begin
    state_d      = state_q;
    used_mask_d  = used_mask_q;
    rand_start_d = rand_start_q;
    game_index_d = game_index_q;
    done         = 1'b0;

    // clear_all wins over every in-flight update, including the COMMIT pulse.
    if (clear_all) begin
      state_d     = StIdle;
      used_mask_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            rand_start_d = lfsr_value;
            state_d      = StDraw;
          end
        end
        StDraw: begin
          if (sel_valid) begin
            game_index_d           = sel_index;
            used_mask_d[sel_index] = 1'b1;
            state_d                = StCommit;
          end else begin
            state_d = StExhausted;
          end
        end
        StCommit: begin
          done    = 1'b1;
          state_d = StIdle;
        end
        StExhausted: begin
`ifdef GAME_DRAW_AUTO_CLEAR_EN
          used_mask_d  = '0;
          rand_start_d = lfsr_value;
          state_d      = StDraw;
`else
          state_d = StExhausted;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      used_mask_q  <= '0;
      rand_start_q <= '0;
      game_index_q <= '0;
    end else begin
      state_q      <= state_d;
      used_mask_q  <= used_mask_d;
      rand_start_q <= rand_start_d;
      game_index_q <= game_index_d;
    end
  end

  assign used_mask  = used_mask_q;
  assign rand_start = rand_start_q;
  assign game_index = game_index_q;
  assign busy       = (state_q != StIdle);
  assign exhausted  = (state_q == StExhausted);

endmodule

// File: doc/game_draw_ctrl.md
GAME_DRAW_CTRL -- requirements
Module: game_draw_ctrl

Interface
REQ-001 Parameter LFSR_SEED, default 7'h5A: nonzero reset value of the start-index LFSR.
REQ-002 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 Port req, input, 1: draw request, sampled only in IDLE.
REQ-005 Port clear_all, input, 1: clears every played flag.
REQ-006 Port used_mask, output, 128: registered played flags; bit i = 1 means game i is played; feeds the selector's gameArray.
REQ-007 Port rand_start, output, 7: registered scan start index; feeds the selector's randomNumber.
REQ-008 Port sel_index, input, 7: selector result; combinational from used_mask/rand_start.
REQ-009 Port sel_valid, input, 1: selector found a zero bit.
REQ-010 Port game_index, output, 7: last committed game.
REQ-011 Port done, output, 1: one-cycle pulse; game_index is new.
REQ-012 Port busy, output, 1: high in any state other than IDLE.
REQ-013 Port exhausted, output, 1: level, high in EXHAUSTED.

Function
REQ-014 LFSR: 7-bit Fibonacci, polynomial x^7+x^6+1, advances every cycle in every state, never 0, period 127.
REQ-015 States: IDLE, DRAW, COMMIT, EXHAUSTED; encoding is local to the block.
REQ-016 IDLE with req=1: capture LFSR value into rand_start; next state DRAW.
REQ-017 DRAW lasts exactly one cycle, which lets the selector settle on registered inputs. At the end of DRAW, sample sel_index/sel_valid.
REQ-018 DRAW with sel_valid=1: game_index<=sel_index; used_mask[sel_index]<=1; next state COMMIT.
REQ-019 DRAW with sel_valid=0: next state EXHAUSTED; used_mask unchanged.
REQ-020 COMMIT: done=1 for this single cycle; next state IDLE.
REQ-021 Latency: req high in IDLE at edge N gives done high in cycle N+2.
REQ-022 A req held high causes back-to-back draws, one every 3 cycles; req is ignored outside IDLE.
REQ-023 EXHAUSTED: behaviour is per REQ-029/REQ-030.
REQ-024 clear_all=1 in any state:
- used_mask<=0, next state IDLE
- aborts any draw; no done
- game_index keeps its value
- priority over req and over the DRAW/COMMIT updates in the same cycle
REQ-025 Start index 0 is never produced by the LFSR; game 0 is still reachable through the selector's wrap-around.

Reset
REQ-026 On reset_n=0 at an edge:
- state IDLE, used_mask=0, rand_start=0, game_index=0
- done=0, busy=0, exhausted=0
- LFSR<=LFSR_SEED
REQ-027 Reset overrides clear_all and req, including mid-draw.

Configuration
REQ-028 Macro GAME_DRAW_AUTO_CLEAR_EN selects how exhaustion is handled.
REQ-029 With GAME_DRAW_AUTO_CLEAR_EN defined, EXHAUSTED lasts one cycle:
- exhausted=1 for that cycle
- used_mask<=0; rand_start<=current LFSR value
- next state DRAW; the pending request completes with a done pulse
REQ-030 Without the macro, EXHAUSTED holds until clear_all or reset; req is ignored there.

Structure
REQ-031 A shared package holds:
- NUM_GAMES=128 and IDX_W=7
- the state enum type
- the LFSR polynomial tap constant
REQ-032 One sub-module, lfsr7, is natural: clock, reset_n, seed parameter, 7-bit value output.
REQ-033 The selector is external; it is wired at the parent level and not instantiated inside this block.

Verification
REQ-034 Reset with LFSR_SEED=7'h5A -> rand_start=0, used_mask=0, all flag outputs 0. One cycle after reset release, the LFSR reads its second sequence value.
REQ-035 Single req, model selector returns (valid, 7'd60):
- done in cycle N+2; game_index=60
- used_mask[60]=1, all other bits 0
REQ-036 128 consecutive draws with a reference-model selector:
- 128 distinct game_index values
- used_mask all ones
- the next req leads to exhausted=1 (macro off)
REQ-037 Macro off, exhausted state; req pulses -> no done. Then clear_all -> IDLE with used_mask=0, and the next req gives done.
REQ-038 Macro on, mask all ones; req -> exhausted pulses 1 cycle, the mask clears, done follows with exactly one bit set.
REQ-039 clear_all asserted during COMMIT -> no done; used_mask=0; state IDLE next cycle.
